// File: rtl/shaper_multi_if.sv
// Sample stream bundle for shaper_multi: tagged input with ready/valid,
// tagged output as a one-cycle pulse with no backpressure.
interface shaper_multi_if #(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned CH_W    = 2,
    parameter int unsigned DRIVE_W = 8
);
    logic signed [WIDTH-1:0]   din;
    logic        [CH_W-1:0]    din_ch;
    logic        [1:0]         din_mode;
    logic        [DRIVE_W-1:0] din_drive;
    logic                      din_valid;
    logic                      din_ready;
    logic signed [WIDTH-1:0]   dout;
    logic        [CH_W-1:0]    dout_ch;
    logic                      dout_valid;

    modport master (
        output din, din_ch, din_mode, din_drive, din_valid,
        input  din_ready, dout, dout_ch, dout_valid
    );

    modport slave (
        input  din, din_ch, din_mode, din_drive, din_valid,
        output din_ready, dout, dout_ch, dout_valid
    );
endinterface

// File: rtl/shaper_multi.sv
// Time-multiplexed waveshaper: drive gain, then bypass / hard clip /
// rational tanh / cubic soft clip. One sample in flight; a single multiplier
// serves gain, a^2 and a^3, and a bit-serial divider serves the tanh curve.
module shaper_multi #(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned NUM_CH  = 4,
    parameter int unsigned CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    parameter int unsigned DRIVE_W = 8
) (
    input logic           clk,
    input logic           rst,
    shaper_multi_if.slave io_bus
);
    localparam int unsigned F     = WIDTH - 1;
    localparam int unsigned DIV_W = 3 * WIDTH + 2;
    localparam int unsigned MA_W  = 2 * F + 1;    // signed multiplier operand A
    localparam int unsigned MB_W  = WIDTH + 1;    // signed multiplier operand B
    localparam int unsigned P_W   = MA_W + MB_W;
    localparam int unsigned CNT_W = $clog2(DIV_W + 1);

    localparam logic signed [P_W-1:0] P_MAX = {{(P_W-F){1'b0}}, {F{1'b1}}};
    localparam logic [DIV_W-1:0] Y_MAX   = {{(DIV_W-F){1'b0}}, {F{1'b1}}};
    localparam logic [DIV_W-1:0] ONE_2F  = {{(DIV_W-2*F-1){1'b0}}, 1'b1, {(2*F){1'b0}}};

    typedef enum logic [2:0] {StIdle, StGain, StMult1, StMult2, StNum, StDiv, StOut} state_e;

    state_e r_state, w_state_next;

    logic signed [WIDTH-1:0] r_din;
    logic [CH_W-1:0]         r_ch;
    logic [1:0]              r_mode;
    logic [DRIVE_W-1:0]      r_drive;
    logic [F-1:0]            r_a;
    logic                    r_s;
    logic [2*F-1:0]          r_a2;
    logic [3*F-1:0]          r_a3;
    logic [F-1:0]            r_y;
    logic [DIV_W-1:0]        r_num, r_den;
    logic signed [WIDTH-1:0] r_dout;
    logic [CH_W-1:0]         r_dout_ch;
    logic                    r_dout_valid;
    logic                    r_div_in_valid;
    logic                    w_div_start;

    // Divider state: r_div_q shifts the dividend out and the quotient in.
    logic [DIV_W-1:0] r_div_q, r_div_rem, r_div_den;
    logic [CNT_W-1:0] r_div_cnt;
    logic             r_div_busy, r_div_out_valid;
    logic [DIV_W:0]   w_div_shift, w_div_diff;
    logic             w_div_ge;

    logic signed [MA_W-1:0]  w_mul_a;
    logic signed [MB_W-1:0]  w_mul_b;
    logic signed [P_W-1:0]   w_mul_p, w_p, w_abs;
    logic [F-1:0]            w_mag, w_r;
    logic                    w_sign;
    logic [DIV_W-1:0]        w_a_ext, w_a2_ext, w_a3_ext, w_3a_hi, w_num, w_den, w_cub;
    logic [WIDTH-1:0]        w_r_ext;
    logic signed [WIDTH-1:0] w_res;

    function automatic logic [F-1:0] sat_f(input logic [DIV_W-1:0] v);
        return (v > Y_MAX) ? {F{1'b1}} : v[F-1:0];
    endfunction

    assign io_bus.din_ready  = (r_state == StIdle);
    assign io_bus.dout       = r_dout;
    assign io_bus.dout_ch    = r_dout_ch;
    assign io_bus.dout_valid = r_dout_valid;

    // Shared multiplier operand select: gain, then a*a, then a2*a.
    always_comb begin
        w_mul_a = {{(MA_W-WIDTH){r_din[WIDTH-1]}}, r_din};
        w_mul_b = {{(MB_W-DRIVE_W){1'b0}}, r_drive};
        if (r_state == StMult1) begin
            w_mul_a = {{(MA_W-F){1'b0}}, r_a};
            w_mul_b = {{(MB_W-F){1'b0}}, r_a};
        end else if (r_state == StMult2) begin
            w_mul_a = {1'b0, r_a2};
            w_mul_b = {{(MB_W-F){1'b0}}, r_a};
        end
        w_mul_p = w_mul_a * w_mul_b;
    end

    // Gain stage: floor shift, symmetric clamp, split into magnitude and sign.
    always_comb begin
        w_p    = w_mul_p >>> 4;
        w_sign = w_p[P_W-1];
        w_abs  = w_sign ? -w_p : w_p;
        w_mag  = (w_abs > P_MAX) ? {F{1'b1}} : w_abs[F-1:0];
    end

    // Curve numerators/denominators, all unsigned in DIV_W bits.
    always_comb begin
        w_a_ext  = DIV_W'(r_a);
        w_a2_ext = DIV_W'(r_a2);
        w_a3_ext = DIV_W'(r_a3);
        w_3a_hi  = ((w_a_ext << 1) + w_a_ext) << (2 * F);
        w_num    = w_3a_hi + w_a3_ext;
        w_den    = ONE_2F + (w_a2_ext << 1) + w_a2_ext;
        w_cub    = (w_3a_hi - w_a3_ext) >> (2 * F + 1);
    end

    // Output formation: bypass passes din verbatim, other modes re-apply the sign.
    always_comb begin
        w_r     = (r_mode == 2'd1) ? r_a : r_y;
        w_r_ext = {1'b0, w_r};
        if (r_mode == 2'd0) begin
            w_res = r_din;
        end else if (r_s) begin
            w_res = -w_r_ext;
        end else begin
            w_res = w_r_ext;
        end
    end

    // Restoring divider step; a borrow out of the trial subtract means "less than".
    always_comb begin
        w_div_shift = {r_div_rem, r_div_q[DIV_W-1]};
        w_div_diff  = w_div_shift - {1'b0, r_div_den};
        w_div_ge    = ~w_div_diff[DIV_W];
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next state and divider start strobe.
    always_comb begin
        w_state_next = r_state;
        w_div_start  = 1'b0;
        unique case (r_state)
            StIdle:  if (io_bus.din_valid) w_state_next = StGain;
            StGain:  w_state_next = r_mode[1] ? StMult1 : StOut;
            StMult1: w_state_next = StMult2;
            StMult2: w_state_next = StNum;
            StNum: begin
                if (r_mode[0]) begin
                    w_state_next = StOut;
                end else begin
                    w_state_next = StDiv;
                    w_div_start  = 1'b1;
                end
            end
            StDiv:   if (r_div_out_valid) w_state_next = StOut;
            StOut:   w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    // Datapath registers, loaded according to the current state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_din          <= '0;
            r_ch           <= '0;
            r_mode         <= '0;
            r_drive        <= '0;
            r_a            <= '0;
            r_s            <= 1'b0;
            r_a2           <= '0;
            r_a3           <= '0;
            r_y            <= '0;
            r_num          <= '0;
            r_den          <= '0;
            r_dout         <= '0;
            r_dout_ch      <= '0;
            r_dout_valid   <= 1'b0;
            r_div_in_valid <= 1'b0;
        end else begin
            r_dout_valid   <= 1'b0;
            r_div_in_valid <= w_div_start;
            unique case (r_state)
                StIdle: begin
                    if (io_bus.din_valid) begin
                        r_din   <= io_bus.din;
                        r_ch    <= io_bus.din_ch;
                        r_mode  <= io_bus.din_mode;
                        r_drive <= io_bus.din_drive;
                    end
                end
                StGain: begin
                    r_a <= w_mag;
                    r_s <= w_sign;
                end
                StMult1: r_a2 <= w_mul_p[2*F-1:0];
                StMult2: r_a3 <= w_mul_p[3*F-1:0];
                StNum: begin
                    if (r_mode[0]) begin
                        r_y <= sat_f(w_cub);
                    end else begin
                        r_num <= w_num;
                        r_den <= w_den;
                    end
                end
                StDiv: if (r_div_out_valid) r_y <= sat_f(r_div_q);
                StOut: begin
                    r_dout       <= w_res;
                    r_dout_ch    <= r_ch;
                    r_dout_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Bit-serial divider: one quotient bit per cycle, truncating toward zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_div_q         <= '0;
            r_div_rem       <= '0;
            r_div_den       <= '0;
            r_div_cnt       <= '0;
            r_div_busy      <= 1'b0;
            r_div_out_valid <= 1'b0;
        end else begin
            r_div_out_valid <= 1'b0;
            if (r_div_in_valid) begin
                r_div_q    <= r_num;
                r_div_rem  <= '0;
                r_div_den  <= r_den;
                r_div_cnt  <= CNT_W'(DIV_W);
                r_div_busy <= 1'b1;
            end else if (r_div_busy) begin
                r_div_rem <= w_div_ge ? w_div_diff[DIV_W-1:0] : w_div_shift[DIV_W-1:0];
                r_div_q   <= {r_div_q[DIV_W-2:0], w_div_ge};
                r_div_cnt <= r_div_cnt - 1'b1;
                if (r_div_cnt == CNT_W'(1)) begin
                    r_div_busy      <= 1'b0;
                    r_div_out_valid <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_shaper_multi.sv
// Randomised bench for shaper_multi against an arithmetic reference model.
module tb_shaper_multi;
    localparam int WIDTH    = 16;
    localparam int NUM_CH   = 4;
    localparam int CH_W     = 2;
    localparam int DRIVE_W  = 8;
    localparam int MAX_WAIT = 200;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    shaper_multi_if #(.WIDTH(WIDTH), .CH_W(CH_W), .DRIVE_W(DRIVE_W)) bus ();

    shaper_multi #(
        .WIDTH  (WIDTH),
        .NUM_CH (NUM_CH),
        .CH_W   (CH_W),
        .DRIVE_W(DRIVE_W)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .io_bus(bus)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Curves evaluated on real-valued fixed point with plain integer arithmetic.
    function automatic int ref_shape(input int x, input int mode, input int drive);
        longint p, a, y, one2f;
        bit s;
        if (mode == 0) return x;
        one2f = longint'(1) << 30;
        p = (longint'(x) * longint'(drive)) >>> 4;
        if (p > 32767) p = 32767;
        if (p < -32767) p = -32767;
        s = (p < 0);
        a = s ? -p : p;
        if (mode == 1) begin
            y = a;
        end else if (mode == 3) begin
            y = (3 * a * one2f - a * a * a) / (one2f * 2);
        end else begin
            y = (3 * a * one2f + a * a * a) / (one2f + 3 * a * a);
        end
        if (y > 32767) y = 32767;
        return int'(s ? -y : y);
    endfunction

    function automatic int ref_latency(input int mode);
        return (mode == 3) ? 5 : 2;
    endfunction

    // Send one sample, scribble on the inputs while busy, wait for the result.
    task automatic send(input int x, input int ch, input int mode, input int drive,
                        output int got, output int got_ch, output int lat, output bit ready_ok);
        int waited = 0;
        while (!bus.din_ready && waited < MAX_WAIT) begin
            @(posedge clk); #1;
            waited++;
        end
        bus.din       = WIDTH'(x);
        bus.din_ch    = CH_W'(ch);
        bus.din_mode  = 2'(mode);
        bus.din_drive = DRIVE_W'(drive);
        bus.din_valid = 1'b1;
        @(posedge clk); #1;
        lat      = 0;
        ready_ok = 1'b1;
        while (lat < MAX_WAIT) begin
            bus.din       = WIDTH'($urandom);
            bus.din_ch    = CH_W'($urandom);
            bus.din_mode  = 2'($urandom);
            bus.din_drive = DRIVE_W'($urandom);
            bus.din_valid = 1'($urandom);
            @(posedge clk); #1;
            lat++;
            if (bus.dout_valid) break;
            if (bus.din_ready) ready_ok = 1'b0;
        end
        bus.din_valid = 1'b0;
        got    = int'(bus.dout);
        got_ch = int'(bus.dout_ch);
    endtask

    task automatic run_case(input string tag, input int x, input int ch, input int mode,
                            input int drive, input int exp);
        int got, got_ch, lat;
        bit ready_ok;
        send(x, ch, mode, drive, got, got_ch, lat, ready_ok);
        check_eq({tag, "_dout"}, got, exp);
        check_eq({tag, "_ch"}, got_ch, ch);
        check_eq({tag, "_ready_low"}, ready_ok, 1);
        if (mode == 2) check_eq({tag, "_done"}, lat < MAX_WAIT, 1);
        else check_eq({tag, "_latency"}, lat, ref_latency(mode));
    endtask

    initial begin
        int q_exp[$];
        int q_ch[$];
        int idx, cycles, got_n, pulses, x, mode, drive, r;
        int bx[8], bm[8], bd[8];
        bit accepted;

        bus.din = '0; bus.din_ch = '0; bus.din_mode = '0; bus.din_drive = '0;
        bus.din_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check_eq("rst_dout", int'(bus.dout), 0);
        check_eq("rst_dout_ch", int'(bus.dout_ch), 0);
        check_eq("rst_dout_valid", bus.dout_valid, 0);
        check_eq("rst_din_ready", bus.din_ready, 1);

        run_case("tanh_half", 16384, 1, 2, 16, 30427);
        @(posedge clk); #1;
        check_eq("dout_valid_pulse", bus.dout_valid, 0);
        run_case("cubic_half", 16384, 2, 3, 16, 22528);
        run_case("cubic_neg_half", -16384, 3, 3, 16, -22528);
        run_case("cubic_full", 32767, 0, 3, 16, 32767);
        run_case("clip_min", -32768, 1, 1, 16, -32767);
        run_case("clip_drive", 4096, 2, 1, 128, 32767);
        run_case("clip_drive0", 12345, 3, 1, 0, 0);
        run_case("tanh_drive0", -20000, 0, 2, 0, 0);
        run_case("bypass", -32768, 1, 0, 200, -32768);

        for (int i = 0; i < 30; i++) begin
            x    = int'($urandom_range(65535)) - 32768;
            mode = int'($urandom_range(3));
            r    = int'($urandom_range(3));
            drive = (r == 0) ? 0 : (r == 1) ? 16 : int'($urandom_range(255));
            run_case("rand", x, i % NUM_CH, mode, drive, ref_shape(x, mode, drive));
        end

        // Back-to-back: din_valid held high, channels 0..3 cycling.
        for (int i = 0; i < 8; i++) begin
            bx[i] = int'($urandom_range(65535)) - 32768;
            bm[i] = int'($urandom_range(3));
            bd[i] = int'($urandom_range(255));
        end
        idx = 0; cycles = 0; got_n = 0;
        bus.din = WIDTH'(bx[0]); bus.din_ch = '0; bus.din_mode = 2'(bm[0]);
        bus.din_drive = DRIVE_W'(bd[0]); bus.din_valid = 1'b1;
        while (got_n < 8 && cycles < 2000) begin
            accepted = bus.din_ready && bus.din_valid;
            @(posedge clk); #1;
            cycles++;
            if (accepted) begin
                q_exp.push_back(ref_shape(bx[idx], bm[idx], bd[idx]));
                q_ch.push_back(idx % NUM_CH);
                idx++;
                if (idx < 8) begin
                    bus.din = WIDTH'(bx[idx]); bus.din_ch = CH_W'(idx % NUM_CH);
                    bus.din_mode = 2'(bm[idx]); bus.din_drive = DRIVE_W'(bd[idx]);
                end else begin
                    bus.din_valid = 1'b0;
                end
            end
            if (bus.dout_valid) begin
                if (q_exp.size() == 0) begin
                    check_eq("b2b_unexpected", 1, 0);
                end else begin
                    check_eq("b2b_dout", int'(bus.dout), q_exp.pop_front());
                    check_eq("b2b_ch", int'(bus.dout_ch), q_ch.pop_front());
                end
                got_n++;
            end
        end
        bus.din_valid = 1'b0;
        check_eq("b2b_count", got_n, 8);
        check_eq("b2b_accepted", idx, 8);

        // Reset while the divider is busy abandons the sample.
        bus.din = WIDTH'(16384); bus.din_ch = 2'd2; bus.din_mode = 2'd2;
        bus.din_drive = 8'd16; bus.din_valid = 1'b1;
        @(posedge clk); #1;
        bus.din_valid = 1'b0;
        repeat (20) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_eq("rst_mid_ready", bus.din_ready, 1);
        check_eq("rst_mid_valid", bus.dout_valid, 0);
        pulses = 0;
        repeat (100) begin
            @(posedge clk); #1;
            if (bus.dout_valid) pulses++;
        end
        check_eq("rst_mid_no_out", pulses, 0);
        run_case("after_rst", 16384, 2, 2, 16, 30427);
        run_case("after_rst_cub", -16384, 1, 3, 16, -22528);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
